// File: rtl/plic_lite_if.sv
// Bus responder interface shared by the interconnect and plic_lite.
// ttype: 1 = WRITE, 0 = READ; tsize: 0 = byte, 1 = half, 2 = word.
interface slave_bus_if;
  logic        ss;
  logic        bstart;
  logic        ttype;
  logic [1:0]  tsize;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        bdone;

  modport slave (
    input  ss, bstart, ttype, tsize, addr, wdata,
    output rdata, bdone
  );

  modport master (
    output ss, bstart, ttype, tsize, addr, wdata,
    input  rdata, bdone
  );
endinterface

// File: rtl/plic_lite.sv
// Lightweight interrupt controller: priority/enable/threshold, claim/complete, one-cycle bus responder.
// Define PLIC_EDGE_EN for an edge-triggered gateway; the default build uses a level gateway.
module plic_lite #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst,
  slave_bus_if.slave       bus,
  input  logic [N_SRC-1:0] irq_src,
  output logic             irq_ext
);

  localparam logic [1:0] TSIZE_WORD = 2'b10;

  typedef enum logic {IDLE, RESP} state_t;
  state_t state_q, state_d;

  logic [8:0]     addr_q;
  logic           wr_q;
  logic           word_q;
  logic [31:0]    wdata_q;
  logic [2:0]     prio_q [1:N_SRC];
  logic [N_SRC:1] enable_q, pending_q, inservice_q;
  logic [N_SRC:1] pending_d, inservice_d, src, set_req;
  logic [2:0]     threshold_q;
  logic [4:0]     best_id;
  logic [2:0]     best_prio;
  logic [4:0]     idx;
  logic [31:0]    read_val;
  logic           prio_sel, wr_go, claim_go, complete_go;
  logic           unused_addr;

  assign src         = irq_src;
  assign idx         = addr_q[6:2];
  assign prio_sel    = (addr_q[8:7] == 2'b00) && (addr_q[1:0] == 2'b00);
  assign unused_addr = ^bus.addr[31:9];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.ss && bus.bstart) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.ss && bus.bstart) begin
      addr_q  <= bus.addr[8:0];
      wr_q    <= bus.ttype;
      word_q  <= (bus.tsize == TSIZE_WORD);
      wdata_q <= bus.wdata;
    end
  end

  // Strict '>' against a running maximum seeded with threshold: ties keep the lowest ID.
  always_comb begin
    best_id   = '0;
    best_prio = threshold_q;
    for (int i = 1; i <= N_SRC; i++) begin
      if (pending_q[i] && enable_q[i] && prio_q[i] > best_prio) begin
        best_id   = 5'(i);
        best_prio = prio_q[i];
      end
    end
  end

  always_comb begin
    read_val = '0;
    case (addr_q)
      9'h080:  read_val[N_SRC:1] = pending_q;
      9'h100:  read_val[N_SRC:1] = enable_q;
      9'h180:  read_val[2:0]     = threshold_q;
      9'h184:  read_val[4:0]     = best_id;
      default: begin
        for (int i = 1; i <= N_SRC; i++)
          if (prio_sel && idx == 5'(i)) read_val[2:0] = prio_q[i];
      end
    endcase
  end

  // Gating with rst keeps an aborted transaction from ever showing bdone.
  assign bus.bdone = (state_q == RESP) && !rst;
  assign bus.rdata = bus.bdone ? read_val : '0;

  assign wr_go       = (state_q == RESP) && wr_q && word_q;
  assign claim_go    = (state_q == RESP) && !wr_q && (addr_q == 9'h184) && (best_id != '0);
  assign complete_go = wr_go && (addr_q == 9'h184) &&
                       (wdata_q >= 32'd1) && (wdata_q <= 32'(N_SRC));

`ifdef PLIC_EDGE_EN
  logic [N_SRC:1] src_prev_q, latch_q, rise;

  assign rise    = src & ~src_prev_q;
  assign set_req = (rise | latch_q) & ~inservice_q;

  // Edges seen while in service wait here until complete releases them.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_prev_q <= '0;
      latch_q    <= '0;
    end else begin
      src_prev_q <= src;
      latch_q    <= (latch_q | rise) & inservice_q;
    end
  end
`else
  assign set_req = src & ~inservice_q;
`endif

  always_comb begin
    pending_d   = pending_q | set_req;
    inservice_d = inservice_q;
    for (int i = 1; i <= N_SRC; i++) begin
      if (claim_go && best_id == 5'(i)) begin
        pending_d[i]   = 1'b0;
        inservice_d[i] = 1'b1;
      end
      if (complete_go && wdata_q[4:0] == 5'(i)) inservice_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q    <= '0;
      threshold_q <= '0;
      pending_q   <= '0;
      inservice_q <= '0;
      irq_ext     <= 1'b0;
      for (int i = 1; i <= N_SRC; i++) prio_q[i] <= '0;
    end else begin
      pending_q   <= pending_d;
      inservice_q <= inservice_d;
      irq_ext     <= (best_id != '0);
      if (wr_go) begin
        case (addr_q)
          9'h100:  enable_q    <= wdata_q[N_SRC:1];
          9'h180:  threshold_q <= wdata_q[2:0];
          default: begin
            for (int i = 1; i <= N_SRC; i++)
              if (prio_sel && idx == 5'(i)) prio_q[i] <= wdata_q[2:0];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_plic_lite.sv
// Scoreboard bench for plic_lite: bus tasks queue expected read data, a negedge monitor compares it.
module tb_plic_lite;
  localparam logic [1:0] WORD = 2'b10;
  localparam logic [1:0] BYTE = 2'b00;
`ifdef PLIC_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  typedef struct {
    bit          is_rd;
    logic [8:0]  addr;
    logic [31:0] exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_src;
  logic       irq_ext;
  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;

  slave_bus_if bus_i ();

  plic_lite #(.N_SRC(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_i),
    .irq_src (irq_src),
    .irq_ext (irq_ext)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_i.bdone === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_bdone: bdone=1 with no transaction outstanding");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_rd) begin
          checks++;
          if (bus_i.rdata !== e.exp) begin
            errors++;
            $display("FAIL rd_%03h: rdata=%08h expected=%08h", e.addr, bus_i.rdata, e.exp);
          end
        end
      end
    end
  end

  task automatic xfer(input bit wr, input logic [8:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic [31:0] exp);
    exp_t e;
    @(negedge clk);
    bus_i.ss     = 1'b1;
    bus_i.bstart = 1'b1;
    bus_i.ttype  = wr;
    bus_i.tsize  = sz;
    bus_i.addr   = {23'h0, a};
    bus_i.wdata  = d;
    e = '{!wr, a, exp};
    sb.push_back(e);
    @(negedge clk);
    checks++;
    if (bus_i.bdone !== 1'b1) begin
      errors++;
      $display("FAIL bdone_latency_%03h: bdone=%b expected=1", a, bus_i.bdone);
    end
    bus_i.ss     = 1'b0;
    bus_i.bstart = 1'b0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    xfer(1'b1, a, d, WORD, 32'h0);
  endtask

  task automatic rd(input logic [8:0] a, input logic [31:0] exp);
    xfer(1'b0, a, 32'h0, WORD, exp);
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%b expected=%b", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    irq_src = '0;
    bus_i.ss = 1'b0; bus_i.bstart = 1'b0; bus_i.ttype = 1'b0;
    bus_i.tsize = WORD; bus_i.addr = '0; bus_i.wdata = '0;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("reset_irq_ext", irq_ext, 1'b0);
    chk("reset_bdone", bus_i.bdone, 1'b0);
    rd(9'h00C, 32'h0);
    rd(9'h100, 32'h0);

    // register access and decode corners
    wr(9'h00C, 32'h5);
    rd(9'h00C, 32'h5);
    wr(9'h000, 32'h7);
    rd(9'h000, 32'h0);
    wr(9'h024, 32'h7);
    rd(9'h024, 32'h0);
    wr(9'h010, 32'hFF);
    rd(9'h010, 32'h7);
    xfer(1'b1, 9'h00C, 32'h1, BYTE, 32'h0);
    rd(9'h00C, 32'h5);
    rd(9'h0C0, 32'h0);
    wr(9'h100, 32'hFFFF_FFFF);
    rd(9'h100, 32'h1FE);

    // threshold masking
    wr(9'h008, 32'h3);
    wr(9'h100, 32'h4);
    wr(9'h180, 32'h3);
    irq_src = 8'h02;
    idle(3);
    chk("masked_irq_ext", irq_ext, 1'b0);
    rd(9'h080, 32'h4);
    wr(9'h180, 32'h2);
    idle(1);
    chk("thr_irq_ext_1cyc", irq_ext, 1'b0);
    idle(1);
    chk("thr_irq_ext_2cyc", irq_ext, 1'b1);
    rd(9'h184, 32'h2);
    rd(9'h080, 32'h0);
    irq_src = 8'h00;
    wr(9'h184, 32'h2);
    rd(9'h080, 32'h0);
    wr(9'h008, 32'h0);
    wr(9'h00C, 32'h0);
    wr(9'h010, 32'h0);
    wr(9'h180, 32'h0);

    // arbitration: 1 and 5 tie at 4, 6 at 2
    wr(9'h004, 32'h4);
    wr(9'h014, 32'h4);
    wr(9'h018, 32'h2);
    wr(9'h100, 32'h1FE);
    irq_src = 8'hFF;
    idle(2);
    rd(9'h184, 32'd1);
    rd(9'h184, 32'd5);
    rd(9'h184, 32'd6);
    rd(9'h184, 32'd0);
    chk("no_cand_irq_ext", irq_ext, 1'b0);
    rd(9'h080, 32'h19C);

    // claim/complete
    wr(9'h184, 32'd7);
    rd(9'h080, 32'h19C);
    wr(9'h184, 32'd1);
    rd(9'h080, EDGE ? 32'h19C : 32'h19E);
    idle(1);
    chk("complete_irq_ext", irq_ext, !EDGE);
    rd(9'h184, EDGE ? 32'd0 : 32'd1);
    rd(9'h080, 32'h19C);

    // reset in the middle of a write
    irq_src = 8'h00;
    @(negedge clk);
    bus_i.ss = 1'b1; bus_i.bstart = 1'b1; bus_i.ttype = 1'b1;
    bus_i.tsize = WORD; bus_i.addr = 32'h180; bus_i.wdata = 32'h5;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus_i.ss = 1'b0; bus_i.bstart = 1'b0;
    @(negedge clk);
    chk("abort_bdone", bus_i.bdone, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rd(9'h180, 32'h0);
    rd(9'h004, 32'h0);
    rd(9'h014, 32'h0);
    rd(9'h100, 32'h0);
    rd(9'h080, 32'h0);
    chk("post_reset_irq_ext", irq_ext, 1'b0);
    wr(9'h004, 32'h1);
    wr(9'h100, 32'h2);
    irq_src = 8'h01;
    idle(2);
    rd(9'h184, 32'd1);

    // pulse while in service: latched only by the edge gateway
    wr(9'h00C, 32'h1);
    wr(9'h100, 32'h8);
    @(negedge clk); irq_src[2] = 1'b1;
    @(negedge clk); irq_src[2] = 1'b0;
    idle(1);
    rd(9'h080, 32'h8);
    rd(9'h184, 32'd3);
    @(negedge clk); irq_src[2] = 1'b1;
    @(negedge clk); irq_src[2] = 1'b0;
    idle(1);
    rd(9'h080, 32'h0);
    wr(9'h184, 32'd3);
    rd(9'h080, EDGE ? 32'h8 : 32'h0);

    idle(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_bdone: %0d transactions never completed, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
